// File: rtl/chan_mux_rr.sv
// ---------------------------------------------------------------------------
// chan_mux_rr
//
// Parametrised channel multiplexer feeding a single registered output stage.
// Each cycle one of CHANNELS producer streams may be granted; its word is
// captured into the output register together with its channel index.
//
// Grant selection:
//   mode = 0  fixed select: channel s is granted when s < CHANNELS and
//             i_valid[s] is high.
//   mode = 1  round-robin: the first valid channel found when scanning
//             ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 is granted, and the
//             pointer then moves to the channel after the granted one.
//
// Handshake semantics (all ports):
//   A word moves across an interface exactly on a rising clock edge where
//   valid and ready are both high. A producer holding valid may not assume
//   the word was taken until it sees ready high at that edge. The output
//   register accepts a new word whenever it is empty or being drained in the
//   same cycle (load_en = !o_valid || o_ready), so back-to-back transfers run
//   at one word per cycle. i_ready is combinational from i_valid, mode, s,
//   o_ready and internal state; o_valid/o_data/o_chan come straight from
//   flops.
//
// Parameters:
//   WIDTH     data bits per channel
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     width of s / o_chan (>= clog2(CHANNELS))
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   i_data   packed channel data, channel k at [k*WIDTH +: WIDTH]
//   i_valid  per-channel data valid
//   i_ready  per-channel accept (one-hot or zero)
//   mode     0 = fixed select, 1 = round-robin
//   s        channel index used in fixed mode
//   o_data   registered selected word
//   o_chan   source channel of o_data
//   o_valid  o_data/o_chan hold a word
//   o_par    (only with CHAN_MUX_PARITY_EN) XOR reduction of o_data,
//            registered with it
//   o_ready  consumer accepts the word
//
// Build option:
//   CHAN_MUX_PARITY_EN  when defined, adds the o_par output.
// ---------------------------------------------------------------------------
module chan_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       i_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          s,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_chan,
  output logic                      o_valid,
`ifdef CHAN_MUX_PARITY_EN
  output logic                      o_par,
`endif
  input  logic                      o_ready
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // -------------------------------------------------------------------------
  if (CHANNELS < 2) begin : g_chk_channels
    $error("chan_mux_rr: CHANNELS must be at least 2");
  end
  if ((1 << SEL_W) < CHANNELS) begin : g_chk_sel_w
    $error("chan_mux_rr: SEL_W too narrow for CHANNELS");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SEL_W-1:0] ptr;        // round-robin search start
  logic             load_en;    // output register may take a new word

  // Grant results
  logic             fix_vld;
  logic [SEL_W-1:0] fix_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] ptr_next;

  assign load_en = !o_valid || o_ready;

  // -------------------------------------------------------------------------
  // Fixed-select grant. Comparing s against every legal channel index
  // means an out-of-range s simply finds no match and never grants.
  // -------------------------------------------------------------------------
  always_comb begin
    fix_vld = 1'b0;
    fix_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s == SEL_W'(k) && i_valid[k]) begin
        fix_vld = 1'b1;
        fix_idx = SEL_W'(k);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin grant. Walk offsets 0..CHANNELS-1 from ptr with explicit
  // wrap; the first valid channel wins. ptr is always kept < CHANNELS, so a
  // single conditional subtract is enough for the modulo.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    rr_vld = 1'b0;
    rr_idx = '0;
    idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!rr_vld && i_valid[idx]) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'(idx);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Mode select and data mux
  // -------------------------------------------------------------------------
  always_comb begin
    grant_vld = mode ? rr_vld : fix_vld;
    grant_idx = mode ? rr_idx : fix_idx;
  end

  // Loop-based mux keeps the slice index bounded even when grant_idx is
  // meaningless (no grant).
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer advance: channel after the granted one, wrapping to 0.
  always_comb begin
    if (grant_idx >= SEL_W'(CHANNELS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SEL_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Input accept. Suppressed during reset so no producer sees a transfer
  // that the reset is about to throw away.
  // -------------------------------------------------------------------------
  always_comb begin
    i_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      i_ready[k] = !rst && load_en && grant_vld && (grant_idx == SEL_W'(k));
    end
  end

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer
  // -------------------------------------------------------------------------
  logic take;   // an input transfer happens this cycle
  assign take = load_en && grant_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data  <= '0;
      o_chan  <= '0;
      o_valid <= 1'b0;
      ptr     <= '0;
    end else begin
      if (take) begin
        o_data  <= grant_data;
        o_chan  <= grant_idx;
        o_valid <= 1'b1;
        if (mode) begin
          ptr <= ptr_next;
        end
      end else if (o_valid && o_ready) begin
        // Drained with nothing to replace it: data/chan keep their value.
        o_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_MUX_PARITY_EN
  // Parity travels with the word it describes, so it only updates on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_par <= 1'b0;
    end else if (take) begin
      o_par <= ^grant_data;
    end
  end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_chan_mux_rr
//
// Directed bench for chan_mux_rr (WIDTH=16, CHANNELS=4, SEL_W=2).
// Inputs change 1 time unit after a rising edge; combinational i_ready is
// checked before the next edge, registered outputs 1 unit after it.
// ---------------------------------------------------------------------------
module tb_chan_mux_rr;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [CHANNELS-1:0]       i_valid;
  logic [CHANNELS-1:0]       i_ready;
  logic                      mode;
  logic [SEL_W-1:0]          s;
  logic [WIDTH-1:0]          o_data;
  logic [SEL_W-1:0]          o_chan;
  logic                      o_valid;
  logic                      o_ready;
`ifdef CHAN_MUX_PARITY_EN
  logic                      o_par;
`endif

  chan_mux_rr #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .mode    (mode),
    .s       (s),
    .o_data  (o_data),
    .o_chan  (o_chan),
    .o_valid (o_valid),
`ifdef CHAN_MUX_PARITY_EN
    .o_par   (o_par),
`endif
    .o_ready (o_ready)
  );

  int checks = 0;
  int errors = 0;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d3, input logic [WIDTH-1:0] d2,
                          input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0);
    i_data = {d3, d2, d1, d0};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] d,
                           input logic [SEL_W-1:0] c, input logic v);
    check({tag, ".o_data"},  32'(o_data),  32'(d));
    check({tag, ".o_chan"},  32'(o_chan),  32'(c));
    check({tag, ".o_valid"}, 32'(o_valid), 32'(v));
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [WIDTH-1:0] fix_exp [4];
    logic [SEL_W-1:0] rr_exp  [6];
    logic [SEL_W-1:0] alt_exp [3];
    fix_exp = '{16'd6234, 16'd725, 16'd7524, 16'd5734};
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    alt_exp = '{2'd1, 2'd3, 2'd1};

    // Reset: all valid, consumer ready, but no accept while in reset.
    rst     = 1'b1;
    mode    = 1'b0;
    s       = '0;
    o_ready = 1'b1;
    i_valid = 4'hF;
    set_data(16'd5734, 16'd7524, 16'd725, 16'd6234);
    tick();
    tick();
    check("reset.i_ready", 32'(i_ready), 32'd0);
    check_out("reset", 16'd0, 2'd0, 1'b0);

    // Fixed mode, s stepping 0..3.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = SEL_W'(k);
      settle();
      check($sformatf("fixed%0d.i_ready", k), 32'(i_ready), 32'(1 << k));
      tick();
      check_out($sformatf("fixed%0d", k), fix_exp[k], SEL_W'(k), 1'b1);
    end

    // Round-robin, all valid: ptr still 0 (held in fixed mode), wraps 3->0.
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("rr%0d.i_ready", k), 32'(i_ready), 32'(1 << rr_exp[k]));
      tick();
      check_out($sformatf("rr%0d", k), fix_exp[rr_exp[k]], rr_exp[k], 1'b1);
    end

    // Round-robin with i_valid=1010 from ptr=0 (fresh reset).
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    i_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("alt%0d.i_ready", k), 32'(i_ready), 32'(1 << alt_exp[k]));
      tick();
      check_out($sformatf("alt%0d", k), fix_exp[alt_exp[k]], alt_exp[k], 1'b1);
    end
    // ptr is now 2.

    // Back-pressure: load 65535 on ch0, then stall 5 cycles.
    mode    = 1'b0;
    s       = 2'd0;
    i_valid = 4'hF;
    set_data(16'd5734, 16'd7524, 16'd725, 16'd65535);
    tick();
    check_out("bp.load", 16'd65535, 2'd0, 1'b1);
    o_ready = 1'b0;
    set_data(16'd5734, 16'd7524, 16'd725, 16'd1234);
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("bp%0d.i_ready", k), 32'(i_ready), 32'd0);
      tick();
      check_out($sformatf("bp%0d", k), 16'd65535, 2'd0, 1'b1);
    end
    // Release: next word loads in the same cycle the held one is consumed.
    o_ready = 1'b1;
    s       = 2'd1;
    settle();
    check("bp.release.i_ready", 32'(i_ready), 32'b0010);
    tick();
    check_out("bp.release", 16'd725, 2'd1, 1'b1);

    // Fixed s=2 with ch2 invalid: no accept, output drains.
    s       = 2'd2;
    i_valid = 4'b1011;
    settle();
    check("noval.i_ready", 32'(i_ready), 32'd0);
    tick();
    check_out("noval", 16'd725, 2'd1, 1'b0);
    tick();
    check_out("noval.idle", 16'd725, 2'd1, 1'b0);

    // Mode change with a held word does not alter it.
    s       = 2'd3;
    i_valid = 4'hF;
    tick();
    check_out("hold.load", 16'd5734, 2'd3, 1'b1);
    o_ready = 1'b0;
    mode    = 1'b1;
    tick();
    check_out("hold.mode", 16'd5734, 2'd3, 1'b1);

    // Reset mid-stream while o_valid=1; ptr was 2, must return to 0.
    rst = 1'b1;
    settle();
    check("midrst.i_ready", 32'(i_ready), 32'd0);
    tick();
    check_out("midrst", 16'd0, 2'd0, 1'b0);
    rst     = 1'b0;
    o_ready = 1'b1;
    settle();
    check("midrst.ptr0.i_ready", 32'(i_ready), 32'b0001);
    tick();
    check_out("midrst.ptr0", 16'd1234, 2'd0, 1'b1);

    // Parity words on ch0 in fixed mode.
    mode = 1'b0;
    s    = 2'd0;
    set_data(16'd5734, 16'd7524, 16'd725, 16'd8224);
    tick();
    check_out("par8224", 16'd8224, 2'd0, 1'b1);
`ifdef CHAN_MUX_PARITY_EN
    check("par8224.o_par", 32'(o_par), 32'd0);
`endif
    set_data(16'd5734, 16'd7524, 16'd725, 16'd9337);
    tick();
    check_out("par9337", 16'd9337, 2'd0, 1'b1);
`ifdef CHAN_MUX_PARITY_EN
    check("par9337.o_par", 32'(o_par), 32'd1);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
